// File: rtl/tx_uart_sched_if.sv
// tx_uart_sched_if
//   Bundles the requester handshakes and the transmitter-side signals of
//   tx_uart_sched.
//   master : requesters + transmitter model (drive i_*, observe o_*)
//   slave  : the scheduler itself (observe i_*, drive o_*)
interface tx_uart_sched_if;
  logic       i_req0_valid;
  logic       i_req1_valid;
  logic [7:0] i_req0_data;
  logic [7:0] i_req1_data;
  logic       o_req0_ready;
  logic       o_req1_ready;
  logic       o_start_tx;
  logic [9:0] o_tx_data;
  logic [3:0] i_bit_tx;
  logic [1:0] o_grant;
  logic       o_busy;
  logic       o_err;

  modport master (
    output i_req0_valid, i_req1_valid, i_req0_data, i_req1_data, i_bit_tx,
    input  o_req0_ready, o_req1_ready, o_start_tx, o_tx_data, o_grant,
           o_busy, o_err
  );

  modport slave (
    input  i_req0_valid, i_req1_valid, i_req0_data, i_req1_data, i_bit_tx,
    output o_req0_ready, o_req1_ready, o_start_tx, o_tx_data, o_grant,
           o_busy, o_err
  );
endinterface

// File: rtl/tx_uart_sched.sv
// tx_uart_sched
//   Two-requester byte scheduler in front of a UART transmitter. Each
//   requester has its own byte FIFO; queued bytes are framed
//   ({stop, byte, start}) and handed to the transmitter one at a time,
//   round-robin between requesters.
// Ports
//   clk        : system clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   bus        : tx_uart_sched_if.slave (requester valid/data/ready,
//                start pulse, frame, bit index, grant, busy, error)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no frame owned; pops a FIFO head when any byte is queued
// WAIT_BUSY | start pulse issued, waiting for the bit index to leave 15
// WAIT_DONE | frame on the line, waiting for the bit index to return to 15
module tx_uart_sched #(
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 4
) (
  input logic            clk,
  input logic            i_reset_n,
  tx_uart_sched_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t state, state_nxt;

  logic [7:0]    mem [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [CW-1:0] cnt [2];

  logic [1:0] vld;
  logic [7:0] din [2];
  logic [1:0] full;
  logic [1:0] ne;
  logic [1:0] push;
  logic [1:0] pop;

  logic          sel1;
  logic          grant_go;
  logic          busy;
  logic          bit_idle;
  logic          rr_q;
  logic [TW-1:0] tmr_q;
  logic          start_q;
  logic [9:0]    tx_data_q;
  logic [1:0]    grant_q;
  logic          err_q;

  assign vld    = {bus.i_req1_valid, bus.i_req0_valid};
  assign din[0] = bus.i_req0_data;
  assign din[1] = bus.i_req1_data;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i] = (cnt[i] == CW'(FIFO_DEPTH));
      ne[i]   = (cnt[i] != '0);
    end
  end

  assign push     = vld & ~full;
  assign bit_idle = (bus.i_bit_tx == 4'hF);

  // A lone non-empty FIFO wins; with both pending the priority pointer decides.
  assign sel1 = ne[1] & (~ne[0] | rr_q);
  assign pop  = {grant_go & sel1, grant_go & ~sel1};

  // FIFO storage (no reset needed: contents only read when count says valid)
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= din[i];
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (|ne) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!bit_idle)        state_nxt = WAIT_DONE;
        else if (tmr_q == '0) state_nxt = IDLE;
      end
      WAIT_DONE: if (bit_idle) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // output / control decode
  always_comb begin
    busy     = 1'b1;
    grant_go = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        grant_go = |ne;
      end
      default: ;
    endcase
  end

  // Frame register, grant, start pulse, start timer and sticky error.
  // The timer is loaded on the grant edge so the first WAIT_BUSY cycle
  // (the start-pulse cycle) counts as the first of START_TIMEOUT cycles.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      start_q   <= 1'b0;
      tx_data_q <= 10'h3FF;
      grant_q   <= 2'b00;
      rr_q      <= 1'b0;
      tmr_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      start_q <= grant_go;
      if (grant_go) begin
        tx_data_q <= {1'b1, (sel1 ? mem[1][rd_ptr[1]] : mem[0][rd_ptr[0]]), 1'b0};
        grant_q   <= sel1 ? 2'b10 : 2'b01;
        rr_q      <= ~sel1;
        tmr_q     <= TW'(START_TIMEOUT - 1);
      end else if (state == WAIT_BUSY) begin
        if (bit_idle) begin
          if (tmr_q == '0) begin
            err_q   <= 1'b1;
            grant_q <= 2'b00;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
      end else if (state == WAIT_DONE && bit_idle) begin
        grant_q <= 2'b00;
      end
    end
  end

  assign bus.o_req0_ready = ~full[0];
  assign bus.o_req1_ready = ~full[1];
  assign bus.o_start_tx   = start_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_grant      = grant_q;
  assign bus.o_busy       = busy;
  assign bus.o_err        = err_q;

endmodule
